// File: rtl/drs_event_reader.sv
// drs_event_reader - frames FWFT readout FIFO words into 16-bit AXI-stream event packets
// Packet: 7 header beats, nwords payload beats, checksum, trailer.
module drs_event_reader #(
  parameter int unsigned TIMEOUT   = 1024,
  parameter logic [15:0] HDR_MARK  = 16'hAAAA,
  parameter logic [15:0] TRL_MARK  = 16'h5555,
  parameter logic [15:0] FILL_WORD = 16'hDEAD
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ev_valid_i,
  output logic        ev_ready_o,
  input  logic [47:0] ev_timestamp_i,
  input  logic [31:0] ev_counter_i,
  input  logic [15:0] ev_nwords_i,
  input  logic [15:0] rd_data_i,
  input  logic        rd_empty_i,
  output logic        rd_enable_o,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        busy_o,
  output logic        err_timeout_o,
  output logic [15:0] pkt_count_o
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_CSUM,
    S_TRAILER
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    beat_q, beat_d;
  logic [47:0]   ts_q, ts_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [15:0]   nwords_q, nwords_d;
  logic [15:0]   remaining_q, remaining_d;
  logic [15:0]   csum_q, csum_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          timed_out_q, timed_out_d;
  logic          err_q, err_d;
  logic [15:0]   tdata_q, tdata_d;
  logic          tvalid_q, tvalid_d;
  logic          tlast_q, tlast_d;
  logic [15:0]   pkt_q, pkt_d;

  logic          load;
  logic          pop;
  logic [15:0]   hdr_word;
  logic [15:0]   pay_word;
  logic [15:0]   remaining_dec;

  // The output register may take a new beat when empty or being drained this cycle.
  assign load          = !tvalid_q || m_axis_tready;
  assign pop           = (state_q == S_PAYLOAD) && load && !rd_empty_i && !timed_out_q;
  assign rd_enable_o   = pop;
  assign ev_ready_o    = (state_q == S_IDLE);
  assign busy_o        = (state_q != S_IDLE);
  assign err_timeout_o = err_q;
  assign pkt_count_o   = pkt_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign remaining_dec = remaining_q - 16'd1;
  assign pay_word      = timed_out_q ? FILL_WORD : rd_data_i;

  always_comb begin
    hdr_word = HDR_MARK;
    case (beat_q)
      3'd1:    hdr_word = cnt_q[31:16];
      3'd2:    hdr_word = cnt_q[15:0];
      3'd3:    hdr_word = ts_q[47:32];
      3'd4:    hdr_word = ts_q[31:16];
      3'd5:    hdr_word = ts_q[15:0];
      3'd6:    hdr_word = nwords_q;
      default: hdr_word = HDR_MARK;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    ts_d        = ts_q;
    cnt_d       = cnt_q;
    nwords_d    = nwords_q;
    remaining_d = remaining_q;
    csum_d      = csum_q;
    to_cnt_d    = to_cnt_q;
    timed_out_d = timed_out_q;
    err_d       = err_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    pkt_d       = pkt_q;

    case (state_q)
      S_IDLE: begin
        if (load) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
        end
        // The first header beat is loaded on accept so it is valid the next cycle.
        if (ev_valid_i) begin
          ts_d        = ev_timestamp_i;
          cnt_d       = ev_counter_i;
          nwords_d    = ev_nwords_i;
          csum_d      = 16'd0;
          to_cnt_d    = '0;
          timed_out_d = 1'b0;
          tdata_d     = HDR_MARK;
          tvalid_d    = 1'b1;
          tlast_d     = 1'b0;
          beat_d      = 3'd1;
          state_d     = S_HEADER;
        end
      end

      S_HEADER: begin
        if (load) begin
          tdata_d  = hdr_word;
          tvalid_d = 1'b1;
          if (beat_q == 3'd6) begin
            beat_d      = 3'd0;
            remaining_d = nwords_q;
            state_d     = (nwords_q == 16'd0) ? S_CSUM : S_PAYLOAD;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end

      S_PAYLOAD: begin
        if (load) begin
          if (timed_out_q || !rd_empty_i) begin
            tdata_d     = pay_word;
            tvalid_d    = 1'b1;
            csum_d      = csum_q + pay_word;
            to_cnt_d    = '0;
            remaining_d = remaining_dec;
            if (remaining_dec == 16'd0) begin
              state_d = S_CSUM;
            end
          end else begin
            tvalid_d = 1'b0;
            to_cnt_d = to_cnt_q + TW'(1);
            if (to_cnt_d == TW'(TIMEOUT)) begin
              timed_out_d = 1'b1;
              err_d       = 1'b1;
            end
          end
        end
      end

      S_CSUM: begin
        if (load) begin
          tdata_d  = csum_q;
          tvalid_d = 1'b1;
          state_d  = S_TRAILER;
        end
      end

      S_TRAILER: begin
        // tlast_q marks that the trailer is already sitting in the output register.
        if (!tlast_q) begin
          if (load) begin
            tdata_d  = TRL_MARK;
            tvalid_d = 1'b1;
            tlast_d  = 1'b1;
          end
        end else if (m_axis_tready) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          pkt_d    = pkt_q + 16'd1;
          state_d  = S_IDLE;
        end
      end

      default: begin
        state_d  = S_IDLE;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      beat_q      <= 3'd0;
      ts_q        <= 48'd0;
      cnt_q       <= 32'd0;
      nwords_q    <= 16'd0;
      remaining_q <= 16'd0;
      csum_q      <= 16'd0;
      to_cnt_q    <= '0;
      timed_out_q <= 1'b0;
      err_q       <= 1'b0;
      tdata_q     <= 16'd0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      pkt_q       <= 16'd0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      ts_q        <= ts_d;
      cnt_q       <= cnt_d;
      nwords_q    <= nwords_d;
      remaining_q <= remaining_d;
      csum_q      <= csum_d;
      to_cnt_q    <= to_cnt_d;
      timed_out_q <= timed_out_d;
      err_q       <= err_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      pkt_q       <= pkt_d;
    end
  end

endmodule

// File: tb/tb_drs_event_reader.sv
// tb/tb_drs_event_reader.sv - self-checking bench for drs_event_reader
// Expected packets are built from descriptor fields and payload words in a queue model.
module tb_drs_event_reader;

  logic        clock = 1'b0;
  logic        reset;
  logic        ev_valid_i;
  logic        ev_ready_o;
  logic [47:0] ev_timestamp_i;
  logic [31:0] ev_counter_i;
  logic [15:0] ev_nwords_i;
  logic [15:0] rd_data_i;
  logic        rd_empty_i;
  logic        rd_enable_o;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        busy_o;
  logic        err_timeout_o;
  logic [15:0] pkt_count_o;

  drs_event_reader dut (
    .clock          (clock),
    .reset          (reset),
    .ev_valid_i     (ev_valid_i),
    .ev_ready_o     (ev_ready_o),
    .ev_timestamp_i (ev_timestamp_i),
    .ev_counter_i   (ev_counter_i),
    .ev_nwords_i    (ev_nwords_i),
    .rd_data_i      (rd_data_i),
    .rd_empty_i     (rd_empty_i),
    .rd_enable_o    (rd_enable_o),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .busy_o         (busy_o),
    .err_timeout_o  (err_timeout_o),
    .pkt_count_o    (pkt_count_o)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  logic [15:0] fifo_q[$];
  logic [15:0] words_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  logic        last_q[$];
  int          tready_mode = 0;
  bit          hold_rand = 0;
  bit          pop_pend = 0;
  bit          acc_pend = 0;
  bit          hold_chk = 0;
  bit          saw_last = 0;
  logic [15:0] prev_tdata = 16'h0;
  int          pops = 0;
  int          exp_pkts = 0;

  task automatic check(input logic [63:0] obs, input logic [63:0] expv, input string tag);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: drive after the rising edge, observe on the falling edge.
  task automatic tick();
    @(posedge clock);
    #1;
    if (pop_pend) begin
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      pops++;
      pop_pend = 0;
    end
    if (acc_pend) begin
      ev_valid_i = 1'b0;
      acc_pend   = 0;
    end
    rd_empty_i = (hold_rand && ($urandom_range(0, 2) == 0)) || (fifo_q.size() == 0);
    rd_data_i  = (fifo_q.size() > 0) ? fifo_q[0] : 16'h0;
    case (tready_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ~m_axis_tready;
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
    @(negedge clock);
    if (rd_enable_o) begin
      pop_pend = 1;
      check(rd_empty_i, 1'b0, "pop_while_empty");
    end
    if (ev_valid_i && ev_ready_o) acc_pend = 1;
    if (hold_chk) begin
      check(m_axis_tvalid, 1'b1, "tvalid_hold");
      check(m_axis_tdata, prev_tdata, "tdata_hold");
    end
    hold_chk   = m_axis_tvalid && !m_axis_tready;
    prev_tdata = m_axis_tdata;
    if (m_axis_tvalid && m_axis_tready) begin
      got_q.push_back(m_axis_tdata);
      last_q.push_back(m_axis_tlast);
      if (m_axis_tlast) saw_last = 1;
    end
  endtask

  // Reference packet: header fields, payload (fill words after the real ones), 16-bit sum, trailer.
  function automatic void build_exp(input logic [47:0] ts, input logic [31:0] c, input logic [15:0] nw);
    int sum = 0;
    logic [15:0] w;
    exp_q.delete();
    exp_q.push_back(16'hAAAA);
    exp_q.push_back(c[31:16]);
    exp_q.push_back(c[15:0]);
    exp_q.push_back(ts[47:32]);
    exp_q.push_back(ts[31:16]);
    exp_q.push_back(ts[15:0]);
    exp_q.push_back(nw);
    for (int i = 0; i < int'(nw); i++) begin
      w = (i < words_q.size()) ? words_q[i] : 16'hDEAD;
      exp_q.push_back(w);
      sum = (sum + int'(w)) % 65536;
    end
    exp_q.push_back(16'(sum));
    exp_q.push_back(16'h5555);
  endfunction

  task automatic run_packet(input logic [47:0] ts, input logic [31:0] c, input logic [15:0] nw,
                            input string tag);
    got_q.delete();
    last_q.delete();
    pops     = 0;
    saw_last = 0;
    fifo_q   = words_q;
    build_exp(ts, c, nw);
    ev_timestamp_i = ts;
    ev_counter_i   = c;
    ev_nwords_i    = nw;
    ev_valid_i     = 1'b1;
    for (int k = 0; k < 6000 && !saw_last; k++) tick();
    check(saw_last, 1'b1, {tag, "_trailer_seen"});
    check(got_q.size(), exp_q.size(), {tag, "_beats"});
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check(got_q[i], exp_q[i], $sformatf("%s_beat%0d", tag, i));
      check(last_q[i], (i == exp_q.size() - 1), $sformatf("%s_tlast%0d", tag, i));
    end
    check(pops, (words_q.size() < int'(nw)) ? words_q.size() : int'(nw), {tag, "_pops"});
    exp_pkts++;
    tick();
    check(pkt_count_o, 16'(exp_pkts), {tag, "_pkt_count"});
    check(busy_o, 1'b0, {tag, "_idle"});
    check(m_axis_tvalid, 1'b0, {tag, "_tvalid_low"});
  endtask

  initial begin
    logic [15:0] nw;
    reset          = 1'b1;
    ev_valid_i     = 1'b0;
    ev_timestamp_i = 48'h0;
    ev_counter_i   = 32'h0;
    ev_nwords_i    = 16'h0;
    rd_data_i      = 16'h0;
    rd_empty_i     = 1'b1;
    m_axis_tready  = 1'b1;
    tick();
    tick();
    check(m_axis_tvalid, 1'b0, "rst_tvalid");
    check(m_axis_tlast, 1'b0, "rst_tlast");
    check(m_axis_tdata, 16'h0, "rst_tdata");
    check(busy_o, 1'b0, "rst_busy");
    check(err_timeout_o, 1'b0, "rst_err");
    check(pkt_count_o, 16'h0, "rst_pkt");
    check(ev_ready_o, 1'b1, "rst_ev_ready");
    check(rd_enable_o, 1'b0, "rst_rd_enable");
    reset = 1'b0;
    tick();

    words_q = '{16'h1, 16'h2, 16'h3, 16'h4};
    tready_mode = 0;
    run_packet(48'h123456789ABC, 32'd7, 16'd4, "basic");

    tready_mode = 1;
    run_packet(48'h123456789ABC, 32'd7, 16'd4, "toggle");

    tready_mode = 0;
    words_q.delete();
    run_packet(48'hFEDCBA987654, 32'h00010002, 16'd0, "empty_pkt");

    words_q = '{16'hFFFF, 16'h0002, 16'h0001};
    run_packet(48'h0, 32'd9, 16'd3, "wrap");
    check(exp_q[10], 16'h0002, "wrap_model_csum");

    words_q = '{16'h0123};
    run_packet(48'h0000_1111_2222, 32'd10, 16'd3, "timeout");
    check(err_timeout_o, 1'b1, "timeout_err");

    for (int r = 0; r < 6; r++) begin
      nw = 16'($urandom_range(0, 12));
      words_q.delete();
      for (int i = 0; i < int'(nw); i++) words_q.push_back(16'($urandom));
      tready_mode = $urandom_range(0, 2);
      hold_rand   = 1'($urandom_range(0, 1));
      run_packet({16'($urandom), 32'($urandom)}, 32'($urandom), nw, $sformatf("rand%0d", r));
    end
    hold_rand = 0;
    check(err_timeout_o, 1'b1, "err_sticky");

    tready_mode = 0;
    words_q = '{16'h11, 16'h22, 16'h33, 16'h44, 16'h55, 16'h66, 16'h77, 16'h88};
    fifo_q  = words_q;
    got_q.delete();
    ev_timestamp_i = 48'h5;
    ev_counter_i   = 32'h6;
    ev_nwords_i    = 16'd8;
    ev_valid_i     = 1'b1;
    for (int k = 0; k < 100 && got_q.size() < 9; k++) tick();
    check(busy_o, 1'b1, "mid_busy");
    reset    = 1'b1;
    pop_pend = 0;
    acc_pend = 0;
    hold_chk = 0;
    ev_valid_i = 1'b0;
    fifo_q.delete();
    tick();
    check(m_axis_tvalid, 1'b0, "mid_rst_tvalid");
    check(m_axis_tlast, 1'b0, "mid_rst_tlast");
    check(ev_ready_o, 1'b1, "mid_rst_ev_ready");
    check(pkt_count_o, 16'h0, "mid_rst_pkt");
    check(err_timeout_o, 1'b0, "mid_rst_err");
    reset    = 1'b0;
    exp_pkts = 0;
    tick();
    words_q = '{16'hA, 16'hB};
    run_packet(48'hABCDEF012345, 32'd99, 16'd2, "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
